// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline hazard/forwarding controller.
//   fwd_sel_e    : encoding of the EX-stage operand 3:1 mux select
//   hz_state_e   : hazard controller FSM states
//   stage_info_t : shadow copy of an instruction held in the EX stage
//   dst_info_t   : destination-only shadow kept for MEM and WB (all forwarding needs)
package riscv_pkg;

    localparam int RV_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LOAD_STALL = 2'b01,
        MEM_WAIT   = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic                 valid;
        logic [RV_REG_AW-1:0] rd;
        logic [RV_REG_AW-1:0] rs1;
        logic [RV_REG_AW-1:0] rs2;
        logic                 regwrite;
        logic                 memread;
    } stage_info_t;

    typedef struct packed {
        logic                 valid;
        logic [RV_REG_AW-1:0] rd;
        logic                 regwrite;
    } dst_info_t;

endpackage

// File: rtl/fwd_sel_gen.sv
// Operand forwarding select for one EX-stage source register.
// Ports:
//   ex_rs    in  source register of the instruction in EX
//   mem_info in  destination shadow of the MEM stage
//   wb_info  in  destination shadow of the WB stage
//   sel      out mux select (FWD_MEM beats FWD_WB beats FWD_REG)
module fwd_sel_gen
    import riscv_pkg::*;
(
    input  logic [RV_REG_AW-1:0] ex_rs,
    input  dst_info_t            mem_info,
    input  dst_info_t            wb_info,
    output fwd_sel_e             sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    assign mem_hit = mem_info.valid & mem_info.regwrite &
                     (mem_info.rd != '0) & (mem_info.rd == ex_rs);
    assign wb_hit  = wb_info.valid & wb_info.regwrite &
                     (wb_info.rd != '0) & (wb_info.rd == ex_rs);

    // MEM holds the younger result, so it wins when both stages write the same rd.
    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage RV32I core.
// Tracks shadow copies of the EX/MEM/WB instructions and drives:
//   fwd_a_sel_o/fwd_b_sel_o : EX operand mux selects (00 regfile, 01 WB, 10 MEM)
//   stall_pc_o/stall_ifid_o : hold PC and IF/ID on a load-use hazard
//   flush_ifid_o            : squash IF/ID on a taken branch
//   bubble_ex_o             : insert a NOP into ID/EX (load-use or branch)
//   freeze_o                : hold all pipeline registers while dmem is busy
//   err_o                   : sticky flag, dmem wait reached MEM_TIMEOUT cycles
// Inputs: clk_i, rst_ni (async active-low), id_* (ID instruction fields),
//   ex_branch_taken_i, dmem_req_i, dmem_ready_i.
module hazard_fwd_ctrl
    import riscv_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              ex_branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_pc_o,
    output logic              stall_ifid_o,
    output logic              flush_ifid_o,
    output logic              bubble_ex_o,
    output logic              freeze_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    stage_info_t      ex_q;
    dst_info_t        mem_q;
    dst_info_t        wb_q;
    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             err_q;
    logic             branch_pend_q;

    logic             freeze;
    logic             mem_wait_req;
    logic             branch_now;
    logic             load_use;
    logic             stall_fire;
    fwd_sel_e         fwd_a;
    fwd_sel_e         fwd_b;

    assign freeze       = (state_q == MEM_WAIT);
    assign mem_wait_req = dmem_req_i & ~dmem_ready_i;

    // A branch seen while frozen is remembered and acted on once the freeze lifts.
    assign branch_now = ~freeze & (ex_branch_taken_i | branch_pend_q);

    assign load_use = ex_q.valid & ex_q.memread & (ex_q.rd != '0) & id_valid_i &
                      ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));

    // Only fires from RUN: the bubble it inserts clears the load from EX, so the
    // same load/user pair cannot stall twice.
    assign stall_fire = (state_q == RUN) & ~branch_now & load_use;

    assign cnt_next = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);

    fwd_sel_gen u_fwd_a (
        .ex_rs    (ex_q.rs1),
        .mem_info (mem_q),
        .wb_info  (wb_q),
        .sel      (fwd_a)
    );

    fwd_sel_gen u_fwd_b (
        .ex_rs    (ex_q.rs2),
        .mem_info (mem_q),
        .wb_info  (wb_q),
        .sel      (fwd_b)
    );

    assign fwd_a_sel_o = fwd_a;
    assign fwd_b_sel_o = fwd_b;
    assign freeze_o    = freeze;
    assign err_o       = err_q;

    always_comb begin
        state_d      = state_q;
        stall_pc_o   = 1'b0;
        stall_ifid_o = 1'b0;
        flush_ifid_o = 1'b0;
        bubble_ex_o  = 1'b0;

        if (branch_now) begin
            flush_ifid_o = 1'b1;
            bubble_ex_o  = 1'b1;
        end else if (stall_fire) begin
            stall_pc_o   = 1'b1;
            stall_ifid_o = 1'b1;
            bubble_ex_o  = 1'b1;
        end

        if (mem_wait_req) begin
            state_d = MEM_WAIT;
        end else begin
            unique case (state_q)
                RUN:     state_d = stall_fire ? LOAD_STALL : RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            branch_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            branch_pend_q <= freeze & (branch_pend_q | ex_branch_taken_i);
            if (state_d != MEM_WAIT) begin
                cnt_q <= '0;
            end else if (freeze) begin
                cnt_q <= cnt_next;
            end
            if (freeze && (cnt_next == TIMEOUT)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            ex_q.valid     <= id_valid_i & ~bubble_ex_o;
            ex_q.rd        <= id_rd_i;
            ex_q.rs1       <= id_rs1_i;
            ex_q.rs2       <= id_rs2_i;
            ex_q.regwrite  <= id_regwrite_i;
            ex_q.memread   <= id_memread_i;
            mem_q.valid    <= ex_q.valid;
            mem_q.rd       <= ex_q.rd;
            mem_q.regwrite <= ex_q.regwrite;
            wb_q           <= mem_q;
        end
    end

endmodule
